// File: rtl/xadc_channel_sequencer_pkg.sv
// Shared widths, XADC auxiliary-channel DRP addresses and sequencer state encoding
// for the XADC round-robin channel sequencer.
package xadc_channel_sequencer_pkg;

   localparam int ADC_W      = 12;
   localparam int DRP_ADDR_W = 7;
   localparam int OFFSET_W   = 13;

   localparam logic [DRP_ADDR_W-1:0] VAUX2  = 7'h12;
   localparam logic [DRP_ADDR_W-1:0] VAUX3  = 7'h13;
   localparam logic [DRP_ADDR_W-1:0] VAUX10 = 7'h1a;
   localparam logic [DRP_ADDR_W-1:0] VAUX11 = 7'h1b;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_ACC,
      ST_PUB
   } seq_state_t;

endpackage

// File: rtl/xadc_channel_sequencer_clamp.sv
// Adds a signed calibration offset to a 12-bit unsigned ADC average and saturates
// the result back into the unsigned 12-bit range [0, 4095].
module adc_offset_clamp
   import xadc_channel_sequencer_pkg::*;
(
   input  logic                       [ADC_W-1:0]    avg_in,
   input  logic signed                [OFFSET_W-1:0] offset_in,
   output logic                       [ADC_W-1:0]    res_out
);

   // Two guard bits: bit 13 flags a negative sum, bit 12 flags a sum above 4095.
   function automatic logic [ADC_W-1:0] sat_u12(input logic signed [ADC_W+1:0] v);
      if (v[ADC_W+1])
         return '0;
      else if (v[ADC_W])
         return '1;
      else
         return v[ADC_W-1:0];
   endfunction

   logic signed [ADC_W+1:0] sum;

   assign sum     = $signed({2'b00, avg_in}) + $signed({offset_in[OFFSET_W-1], offset_in});
   assign res_out = sat_u12(sum);

endmodule

// File: rtl/xadc_channel_sequencer.sv
// Round-robin XADC DRP read sequencer: per-channel averaging, offset calibration,
// drdy timeout detection and a single coherent publish strobe for all channels.
module xadc_channel_sequencer
   import xadc_channel_sequencer_pkg::*;
#(
   parameter int                             NUM_CH     = 2,
   parameter logic [NUM_CH*DRP_ADDR_W-1:0]   CH_ADDRS   = {VAUX10, VAUX11},
   parameter logic [NUM_CH*OFFSET_W-1:0]     CH_OFFSETS = {13'sd24, -13'sd8},
   parameter int                             AVG_LOG2   = 2,
   parameter int                             TIMEOUT    = 64
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         enable,
   input  logic                         err_clr,
   input  logic                         eoc_in,
   input  logic                         drdy_in,
   input  logic [15:0]                  do_in,
   output logic                         den_out,
   output logic [DRP_ADDR_W-1:0]        daddr_out,
   output logic [NUM_CH*ADC_W-1:0]      data_out,
   output logic                         valid_out,
   output logic [NUM_CH-1:0]            err_out,
   output logic                         busy_out
);

   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int RND_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam int ACC_W = ADC_W + AVG_LOG2;
   localparam int TMO_W = $clog2(TIMEOUT + 1);

   localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
   localparam logic [RND_W-1:0] LAST_RND = RND_W'((1 << AVG_LOG2) - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

   seq_state_t           state;
   seq_state_t           state_nxt;
   logic [CH_W-1:0]      ch;
   logic [RND_W-1:0]     round;
   logic [TMO_W-1:0]     tmo;
   logic [ADC_W-1:0]     sample;
   logic [ACC_W-1:0]     acc      [NUM_CH];
   logic [ACC_W-1:0]     acc_nxt  [NUM_CH];
   logic [ADC_W-1:0]     last_raw [NUM_CH];
   logic [NUM_CH-1:0]    err_set;
   logic [NUM_CH*ADC_W-1:0] pub_res;
   logic                 last_sample;
   logic                 tmo_expired;
   logic [3:0]           unused_do_lsbs;

   assign unused_do_lsbs = do_in[3:0];
   assign last_sample    = (ch == LAST_CH) && (round == LAST_RND);
   assign tmo_expired    = (tmo == TMO_LAST) && !drdy_in;
   assign daddr_out      = CH_ADDRS[int'(ch)*DRP_ADDR_W +: DRP_ADDR_W];

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      den_out   = 1'b0;
      valid_out = 1'b0;
      busy_out  = (state != ST_IDLE);
      case (state)
         ST_IDLE: if (enable && eoc_in) state_nxt = ST_REQ;
         ST_REQ: begin
            den_out   = 1'b1;
            state_nxt = ST_WAIT;
         end
         ST_WAIT: if (drdy_in || tmo_expired) state_nxt = ST_ACC;
         ST_ACC:  state_nxt = last_sample ? ST_PUB : ST_IDLE;
         ST_PUB: begin
            valid_out = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      err_set = '0;
      if (state == ST_WAIT && tmo_expired)
         err_set[ch] = 1'b1;
   end

   // Accumulator view including the sample being added this cycle; the publish
   // path reads it so data_out is already updated while valid_out is high.
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         acc_nxt[c] = acc[c];
         if (CH_W'(c) == ch)
            acc_nxt[c] = acc[c] + ACC_W'(sample);
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_clamp
      adc_offset_clamp u_clamp (
         .avg_in    (acc_nxt[g][ACC_W-1:AVG_LOG2]),
         .offset_in ($signed(CH_OFFSETS[g*OFFSET_W +: OFFSET_W])),
         .res_out   (pub_res[g*ADC_W +: ADC_W])
      );
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ch       <= '0;
         round    <= '0;
         tmo      <= '0;
         sample   <= '0;
         data_out <= '0;
         err_out  <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            acc[c]      <= '0;
            last_raw[c] <= '0;
         end
      end else begin
         // Set wins over a coincident clear on the same bit.
         err_out <= (err_out & ~{NUM_CH{err_clr}}) | err_set;
         case (state)
            ST_IDLE: begin
               if (!enable) begin
                  ch    <= '0;
                  round <= '0;
                  for (int c = 0; c < NUM_CH; c++) acc[c] <= '0;
               end
            end
            ST_REQ: tmo <= '0;
            ST_WAIT: begin
               if (drdy_in) begin
                  sample       <= do_in[15:4];
                  last_raw[ch] <= do_in[15:4];
               end else if (tmo == TMO_LAST) begin
                  sample <= last_raw[ch];
               end else begin
                  tmo <= tmo + 1'b1;
               end
            end
            ST_ACC: begin
               if (last_sample) begin
                  data_out <= pub_res;
               end else if (!enable) begin
                  ch    <= '0;
                  round <= '0;
                  for (int c = 0; c < NUM_CH; c++) acc[c] <= '0;
               end else begin
                  for (int c = 0; c < NUM_CH; c++) acc[c] <= acc_nxt[c];
                  if (ch == LAST_CH) begin
                     ch    <= '0;
                     round <= round + 1'b1;
                  end else begin
                     ch <= ch + 1'b1;
                  end
               end
            end
            ST_PUB: begin
               ch    <= '0;
               round <= '0;
               for (int c = 0; c < NUM_CH; c++) acc[c] <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule
